// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

    // Width of one packed BCD digit.
    localparam int BCD_DIGIT_W = 4;

    // Converter control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Decimal digits needed for the largest w-bit unsigned value: ceil(w*log10(2)).
    // log10(2) is held as a 12-digit fixed-point fraction. w*log10(2) is never an
    // integer for w>0, so the ceiling stays exact over the legal width range.
    function automatic int digits_for_width(input int w);
        longint num;
        num = longint'(w) * 64'd301029995664;
        return int'((num + 64'd999999999999) / 64'd1000000000000);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 to a BCD digit of 5 or more, so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bin_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] dig_i,
    output logic [BCD_DIGIT_W-1:0] dig_o
);

    // Add-3 correction ahead of the shift.
    always_comb begin
        dig_o = dig_i;
        if (dig_i >= 4'd5) begin
            dig_o = dig_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with valid/ready handshakes on both sides and a sticky digit-overflow flag.
// Optional macro BIN_TO_BCD_SEQ_SIGNED_EN: treat I_DAT as two's complement,
// convert its magnitude and report the sign on O_NEG.
module bin_to_bcd_seq
    import bin_bcd_pkg::*;
#(
    parameter int W      = 32,
    parameter int DIGITS = 10
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [W-1:0]        I_DAT,
    input  logic                I_STB,
    output logic                I_ACK,
    output logic [4*DIGITS-1:0] O_DAT,
    output logic                O_STB,
    input  logic                O_ACK,
    output logic                O_OVF
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
    ,
    output logic                O_NEG
`endif
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    state_t             state_q, state_d;
    logic [W-1:0]       shr_q, shr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [W-1:0]       load_val;
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
    logic               neg_q, neg_d;
`endif

    // Per-digit add-3 correction of the current accumulator.
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i (acc_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .dig_o (acc_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // Operand loaded on accept: raw value, or its magnitude in the signed build.
    // The most-negative value negates to itself, which is its exact magnitude
    // when read as unsigned.
    always_comb begin
        load_val = I_DAT;
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
        if (I_DAT[W-1]) begin
            load_val = -I_DAT;
        end
`endif
    end

    // Control state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset clears the result so nothing stale is ever shown.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shr_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
            neg_q <= 1'b0;
`endif
        end else begin
            shr_q <= shr_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
            neg_q <= neg_d;
`endif
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d = state_q;
        shr_d   = shr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
        neg_d   = neg_q;
`endif
        I_ACK   = 1'b0;
        O_STB   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                I_ACK = 1'b1;
                if (I_STB) begin
                    shr_d   = load_val;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(W);
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
                    neg_d   = I_DAT[W-1];
`endif
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // Shift the corrected accumulator left, pulling in the next binary
                // bit; a bit leaving the top digit means the value exceeds DIGITS.
                acc_d = {acc_adj[ACC_W-2:0], shr_q[W-1]};
                shr_d = {shr_q[W-2:0], 1'b0};
                ovf_d = ovf_q | acc_adj[ACC_W-1];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                O_STB = 1'b1;
                if (O_ACK) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result is held in the accumulator until the downstream handshake.
    assign O_DAT = acc_q;
    assign O_OVF = ovf_q;
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
    assign O_NEG = neg_q;
`endif

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Parametrised, iterative binary-to-BCD converter (shift-and-add-3 / double-dabble). It processes one input bit per clock.
- Replaces the single-cycle divide/modulo converter on wide datapaths where area and timing matter.
- Sits between a binary counter/measurement source and the display/UART formatting stage.
- Adds a valid/ready handshake on both sides, a digit-count overflow flag, and back-pressure holding.

Parameters:
- W, 32, input binary width in bits (legal 4..64).
- DIGITS, 10, BCD output digits; O_DAT width is 4*DIGITS (legal 1..20).

Ports:
- CLK  in  1  clock, all logic rising-edge.
- RST  in  1  synchronous active-high reset.
- I_DAT  in  W  binary input value, sampled on accept.
- I_STB  in  1  input valid.
- I_ACK  out  1  input ready; high only in IDLE.
- O_DAT  out  4*DIGITS  BCD result, digit k at bits [4k+3:4k], digit 0 = units.
- O_STB  out  1  output valid.
- O_ACK  in  1  downstream ready.
- O_OVF  out  1  result did not fit in DIGITS digits; valid with O_STB.

Behaviour:
- Reset is synchronous to CLK and active-high. RST=1 at a rising edge:
  - forces state IDLE;
  - clears O_DAT=0, O_STB=0, O_OVF=0;
  - sets I_ACK=1 from the next cycle.
  - Reset mid-conversion or mid-output abandons the transfer; no partial result is ever presented.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - I_ACK=1.
  - Accept occurs when I_STB&I_ACK at a rising edge: load shift register from I_DAT, clear the BCD accumulator and overflow flag, load bit counter with W, go to SHIFT.
- SHIFT, once per cycle:
  - Every 4-bit digit >=5 gets +3.
  - Then {accumulator, shift register} shifts left by 1, with the MSB of the shift register entering digit 0 bit 0.
  - Any 1 shifted out of the top digit sets the sticky overflow flag.
  - The counter decrements; when it reaches 0 (after exactly W shift cycles), go to DONE.
- DONE:
  - O_STB=1, O_DAT=accumulator, O_OVF=flag.
  - All three hold stable while O_ACK=0.
  - On O_STB&O_ACK, go to IDLE.
- Latency: accept at edge N means O_STB=1 in the cycle after edge N+W.
- Throughput: one result per W+2 cycles with O_ACK tied high.
- I_ACK=0 in SHIFT and DONE. I_DAT/I_STB are ignored there; the upstream source must hold its data until acknowledged.
- Ack and re-accept: O_ACK and a new I_STB in the same cycle do not overlap. The new input is accepted in the following IDLE cycle (no bypass).
- Overflow: when O_OVF=1, O_DAT holds the value mod 10^DIGITS.
  - With default W=32, DIGITS=10 overflow is impossible and O_OVF stays 0.
- Zero input: result all-zero digits.
- Every output digit is always in 0..9.
- Arithmetic:
  - Accumulator width is exactly 4*DIGITS.
  - Shift register width is exactly W.
  - Counter width is clog2(W+1).

Optional Feature:
- Macro BIN_TO_BCD_SEQ_SIGNED_EN.
- When defined:
  - I_DAT is two's complement.
  - On accept, the magnitude is loaded. The most-negative input 2^(W-1) is represented exactly in W unsigned bits.
  - Extra output port O_NEG (out, 1) holds the input sign. It is valid with O_STB and reset to 0.
- When not defined: I_DAT is unsigned, O_NEG does not exist, and the behaviour is exactly as above.

Decomposition:
- Package bin_bcd_pkg contains:
  - state enum (ST_IDLE, ST_SHIFT, ST_DONE);
  - BCD_DIGIT_W=4;
  - constant function digits_for_width(w) = ceil(w*log10(2)), used by instantiators to size DIGITS.
- One sub-module: bcd_digit_adj, a combinational 4-bit "add 3 if >=5". It is instantiated DIGITS times via generate inside the SHIFT datapath.

Test Plan:
- Basic conversion: W=32, DIGITS=10, I_DAT=0xFFFFFFFF, O_ACK=1 -> O_STB exactly 33 cycles after accept, O_DAT=0x4294967295, O_OVF=0.
- Zero and small values: I_DAT=0 -> O_DAT=0; I_DAT=9 -> O_DAT=0x9; I_DAT=10 -> O_DAT=0x10.
- Back-pressure: O_ACK=0 for 20 cycles after O_STB -> O_DAT/O_STB stable, I_ACK=0 throughout; a new I_STB is accepted only in the cycle after O_ACK=1.
- Overflow: W=16, DIGITS=4, I_DAT=12345 -> O_DAT=0x2345, O_OVF=1; I_DAT=9999 -> O_OVF=0.
- Reset mid-operation: RST pulse 10 cycles after accept -> O_STB=0, I_ACK=1 next cycle; the next input 1234 converts correctly to 0x1234.
- Signed build (BIN_TO_BCD_SEQ_SIGNED_EN), W=32: I_DAT=0x80000000 -> O_DAT=0x2147483648, O_NEG=1; I_DAT=-1 -> O_DAT=0x1, O_NEG=1.
